// File: rtl/dda_state_streamer_pkg.sv
// Shared types and constants for the DDA state streamer: FSM states,
// frame geometry and the frame byte selector.
package dda_state_streamer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_CAPTURE,
    ST_SEND
  } state_t;

  localparam int FRAME_BYTES = 7;
  localparam int IDX_W = $clog2(FRAME_BYTES);
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef logic [IDX_W-1:0] byte_idx_t;
  typedef logic [7:0] frame_byte_t;

  // Frame layout: sync, then x, y, z each most-significant byte first.
  function automatic frame_byte_t frame_byte(input logic [47:0] snap,
                                             input frame_byte_t sync,
                                             input byte_idx_t idx);
    case (idx)
      3'd0:    frame_byte = sync;
      3'd1:    frame_byte = snap[47:40];
      3'd2:    frame_byte = snap[39:32];
      3'd3:    frame_byte = snap[31:24];
      3'd4:    frame_byte = snap[23:16];
      3'd5:    frame_byte = snap[15:8];
      3'd6:    frame_byte = snap[7:0];
      default: frame_byte = '0;
    endcase
  endfunction

endpackage

// File: rtl/dda_stream_if.sv
// Byte-serial valid/ready stream from the state streamer toward the pad wrapper.
interface dda_stream_if;
  import dda_state_streamer_pkg::*;

  frame_byte_t out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/dda_state_streamer_byte_frame_tx.sv
// Holds one 48-bit snapshot and emits it as sync + 6 bytes under valid/ready.
// done is a same-cycle pulse marking acceptance of the last byte.
module dda_state_streamer_byte_frame_tx
  import dda_state_streamer_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [47:0]          snapshot,
  dda_stream_if.master         stream,
  output logic                 done
);

  logic [47:0] snap;
  byte_idx_t   idx;
  logic        accept;

  assign accept = stream.out_valid & stream.out_ready;
  assign done   = accept & (idx == byte_idx_t'(FRAME_BYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap             <= '0;
      idx              <= '0;
      stream.out_data  <= '0;
      stream.out_valid <= 1'b0;
    end else if (load) begin
      snap             <= snapshot;
      idx              <= '0;
      stream.out_data  <= SYNC_BYTE;
      stream.out_valid <= 1'b1;
    end else if (accept) begin
      if (idx == byte_idx_t'(FRAME_BYTES - 1)) begin
        idx              <= '0;
        stream.out_data  <= '0;
        stream.out_valid <= 1'b0;
      end else begin
        // Data only moves on a handshake, so it holds steady under backpressure.
        idx             <= idx + 1'b1;
        stream.out_data <= frame_byte(snap, SYNC_BYTE, idx + 1'b1);
      end
    end
  end

endmodule

// File: rtl/dda_state_streamer.sv
// Sequences the Lorenz DDA integrator (IC load, N steps) and streams atomic
// {x,y,z} snapshots as 7-byte frames.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | outputs low, waiting for start
//   INIT    | dda_en=1, dda_rst=1 for one cycle: integrator loads ICs
//   RUN     | dda_en=1 for max(decim,1) cycles, down-counting step_cnt
//   CAPTURE | integrator frozen, {x,y,z} latched into the frame tx
//   SEND    | integrator frozen while the frame drains; stop sampled at end
module dda_state_streamer
  import dda_state_streamer_pkg::*;
#(
  parameter int         N         = 16,
  parameter int         ES        = 1,
  parameter int         DECIM_W   = 8,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [DECIM_W-1:0] decim,
  input  logic [N-1:0]       x,
  input  logic [N-1:0]       y,
  input  logic [N-1:0]       z,
  output logic               dda_en,
  output logic               dda_rst,
  output logic               busy,
  dda_stream_if.master       stream
);

  if (N != 16 || ES > 3) begin : g_cfg_err
    $error("dda_state_streamer: frame layout needs N=16 and a sane ES");
  end

  state_t             state;
  logic [DECIM_W-1:0] step_cnt;
  logic               frame_done;

  dda_state_streamer_byte_frame_tx #(
    .SYNC_BYTE (SYNC_BYTE)
  ) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == ST_CAPTURE),
    .snapshot ({x, y, z}),
    .stream   (stream),
    .done     (frame_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      dda_en   <= 1'b0;
      dda_rst  <= 1'b0;
      busy     <= 1'b0;
      step_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_INIT;
            dda_en  <= 1'b1;
            dda_rst <= 1'b1;
            busy    <= 1'b1;
          end
        end
        // First frame after INIT carries the initial conditions untouched.
        ST_INIT: begin
          state   <= ST_CAPTURE;
          dda_en  <= 1'b0;
          dda_rst <= 1'b0;
        end
        ST_CAPTURE: begin
          state <= ST_SEND;
        end
        ST_SEND: begin
          if (frame_done) begin
            if (stop) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state    <= ST_RUN;
              dda_en   <= 1'b1;
              step_cnt <= (decim == '0) ? '0 : decim - 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (step_cnt == '0) begin
            state  <= ST_CAPTURE;
            dda_en <= 1'b0;
          end else begin
            step_cnt <= step_cnt - 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          dda_en  <= 1'b0;
          dda_rst <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dda_state_streamer.sv
// Scoreboard bench: a stand-in DDA integrator feeds the streamer; expected
// frames come from iterating the step function a computed number of times.
module tb_dda_state_streamer;
  import dda_state_streamer_pkg::*;

  localparam int LIMIT = 3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [7:0]  decim = 8'd0;
  logic [15:0] x = '0, y = '0, z = '0;
  logic        dda_en, dda_rst, busy;
  logic [47:0] ic = '0;

  dda_stream_if stream ();

  dda_state_streamer #(
    .N(16), .ES(1), .DECIM_W(8), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .decim   (decim),
    .x       (x),
    .y       (y),
    .z       (z),
    .dda_en  (dda_en),
    .dda_rst (dda_rst),
    .busy    (busy),
    .stream  (stream)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] dda_step(input logic [47:0] s);
    logic [15:0] a, b, c;
    a = s[47:32]; b = s[31:16]; c = s[15:0];
    return {16'(a + ((b - a) >> 3) + 16'd1), 16'(b + (a >> 2) - (c >> 4)), 16'(c + (a ^ b) - 16'd3)};
  endfunction

  function automatic logic [47:0] state_after(input logic [47:0] s0, input int n);
    logic [47:0] s;
    s = s0;
    for (int i = 0; i < n; i++) s = dda_step(s);
    return s;
  endfunction

  // Stand-in integrator: loads ICs on en&rst, otherwise steps on en.
  always @(posedge clk) begin
    if (dda_en) begin
      if (dda_rst) {x, y, z} <= ic;
      else         {x, y, z} <= dda_step({x, y, z});
    end
  end

  int checks = 0;
  int passes = 0;
  int acc_bytes = 0;
  int en_run = 0;
  int cur_eff = 1;
  int ready_mode = 0;
  int stall_left = 0;
  bit first_frame = 1'b0;
  logic pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = '0;
  logic [7:0] exp_q[$];

  task automatic check(input bit ok, input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic push_frames(input logic [47:0] ic_v, input int eff, input int nfr);
    logic [47:0] s;
    for (int f = 0; f < nfr; f++) begin
      s = state_after(ic_v, f * eff);
      exp_q.push_back(8'hA5);
      for (int b = 5; b >= 0; b--) exp_q.push_back(s[b*8 +: 8]);
    end
  endtask

  task automatic wait_busy(input logic lvl);
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      if (busy == lvl) return;
    end
    check(1'b0, "busy_timeout", busy, lvl);
  endtask

  task automatic wait_bytes(input int n);
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      if (acc_bytes >= n) return;
    end
    check(1'b0, "byte_timeout", 48'(acc_bytes), 48'(n));
  endtask

  task automatic setup_run(input logic [47:0] ic_v, input int d, input int mode);
    ic = ic_v;
    decim = 8'(d);
    cur_eff = (d == 0) ? 1 : d;
    ready_mode = mode;
  endtask

  task automatic check_idle_after_stop();
    check(exp_q.size() == 0, "frames_left", 48'(exp_q.size()), 0);
    check(stream.out_valid == 1'b0 && busy == 1'b0, "idle_after_stop", {stream.out_valid, busy}, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check(dda_en == 1'b0 && busy == 1'b0, "idle_quiet", {dda_en, busy}, 0);
    end
  endtask

  task automatic do_run(input logic [47:0] ic_v, input int d, input int nfr, input int mode, input bit stall);
    int base;
    setup_run(ic_v, d, mode);
    push_frames(ic_v, cur_eff, nfr);
    base = acc_bytes;
    @(negedge clk);
    start = 1'b1;
    wait_busy(1'b1);
    start = 1'b0;
    if (stall) begin
      wait_bytes(base + 2);
      stall_left = 20;
    end
    wait_bytes(base + (nfr - 1) * 7 + 3);
    stop = 1'b1;
    wait_busy(1'b0);
    stop = 1'b0;
    check_idle_after_stop();
  endtask

  // Monitor: pops expected bytes on every handshake and drives out_ready.
  initial begin
    logic rdy;
    logic [7:0] e;
    int exp_en;
    stream.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (dda_rst) begin
          check(dda_en == 1'b1, "rst_without_en", dda_en, 1);
          first_frame = 1'b1;
          en_run = 0;
        end else if (dda_en) begin
          en_run++;
        end
        if (pv && !pr)
          check(stream.out_valid == 1'b1 && stream.out_data == pd, "stall_hold",
                {stream.out_valid, stream.out_data}, {1'b1, pd});
        if (stream.out_valid) begin
          check(dda_en == 1'b0, "en_during_send", dda_en, 0);
          if (!pv) begin
            exp_en = first_frame ? 0 : cur_eff;
            check(en_run == exp_en, "steps_between_frames", 48'(en_run), 48'(exp_en));
            first_frame = 1'b0;
            en_run = 0;
          end
        end
        if (stall_left > 0) begin
          rdy = 1'b0;
          stall_left--;
        end else if (ready_mode == 1) begin
          rdy = 1'($urandom_range(0, 1));
        end else begin
          rdy = 1'b1;
        end
        stream.out_ready = rdy;
        if (stream.out_valid && rdy) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_byte", stream.out_data, 0);
          end else begin
            e = exp_q.pop_front();
            check(stream.out_data == e, "frame_byte", stream.out_data, e);
          end
          acc_bytes++;
        end
        pv = stream.out_valid;
        pr = rdy;
        pd = stream.out_data;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [47:0] ic_a;
    repeat (3) @(negedge clk);
    check(stream.out_valid == 1'b0, "reset_out_valid", stream.out_valid, 0);
    check(stream.out_data == 8'h00, "reset_out_data", stream.out_data, 0);
    check(busy == 1'b0, "reset_busy", busy, 0);
    check(dda_en == 1'b0 && dda_rst == 1'b0, "reset_dda", {dda_en, dda_rst}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_run(48'h4000_3C00_1234, 0, 3, 0, 1'b0);
    do_run({$urandom(), $urandom()}, 5, 3, 0, 1'b0);
    do_run({$urandom(), $urandom()}, $urandom_range(1, 4), 3, 1, 1'b1);

    // Asynchronous reset in the middle of a frame.
    setup_run({$urandom(), $urandom()}, 2, 0);
    push_frames(ic, cur_eff, 1);
    base = acc_bytes;
    @(negedge clk);
    start = 1'b1;
    wait_busy(1'b1);
    start = 1'b0;
    wait_bytes(base + 3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check(stream.out_valid == 1'b0 && busy == 1'b0, "async_reset_drop", {stream.out_valid, busy}, 0);
    exp_q.delete();
    pv = 1'b0;
    pr = 1'b0;
    stall_left = 0;
    #1 rst_n = 1'b1;
    do_run({$urandom(), $urandom()}, 3, 2, 0, 1'b0);

    // start held high across stop: ICs reloaded for the second run.
    ic_a = {$urandom(), $urandom()};
    setup_run(ic_a, 4, 1);
    push_frames(ic_a, cur_eff, 2);
    push_frames(ic_a, cur_eff, 1);
    base = acc_bytes;
    @(negedge clk);
    start = 1'b1;
    wait_bytes(base + 7 + 3);
    stop = 1'b1;
    wait_busy(1'b0);
    wait_busy(1'b1);
    wait_busy(1'b0);
    start = 1'b0;
    stop = 1'b0;
    check_idle_after_stop();

    for (int r = 0; r < 4; r++)
      do_run({$urandom(), $urandom()}, $urandom_range(0, 6), $urandom_range(1, 4), 1, r[0]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
